// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Per-stage stall/flush mask generator for memory waits, load-use
//            bubbles and taken-branch flushes. Optional early memory completion
//            is enabled by defining PIPE_STALL_MEM_READY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 4,
    parameter int MEM_STAGE  = 3,
    parameter int BR_STAGE   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNT_W-1:0]      i_mem_data_access,
    input  logic                  i_branch_met,
    input  logic                  i_load_use,
    input  logic                  i_mem_ready,
    output logic [NUM_STAGES-1:0] o_stall_r,
    output logic [NUM_STAGES-1:0] o_flush_r,
    output logic                  o_busy_r
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_BUBBLE   = 2'd2;

    localparam logic [NUM_STAGES-1:0] c_ALL      = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] c_UP_MASK  = c_ALL >> (NUM_STAGES - 1 - MEM_STAGE);
    localparam logic [NUM_STAGES-1:0] c_DN_MASK  = ~c_UP_MASK;
    localparam logic [NUM_STAGES-1:0] c_BR_FLUSH = c_ALL >> (NUM_STAGES - BR_STAGE);
    localparam logic [NUM_STAGES-1:0] c_BR_BIT   = {{(NUM_STAGES-1){1'b0}}, 1'b1} << BR_STAGE;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_first_nxt;
    logic                  w_mem_done;
    logic [NUM_STAGES-1:0] w_stall_nxt;
    logic [NUM_STAGES-1:0] w_flush_nxt;
    logic                  w_busy_nxt;

`ifdef PIPE_STALL_MEM_READY_EN
    assign w_mem_done = i_mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = i_mem_ready;
    assign w_mem_done         = 1'b0;
`endif

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            o_stall_r <= '0;
            o_flush_r <= '0;
            o_busy_r  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            o_stall_r <= w_stall_nxt;
            o_flush_r <= w_flush_nxt;
            o_busy_r  <= w_busy_nxt;
        end
    end

    // Next state; w_first_nxt marks that the upcoming cycle is the first wait cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_first_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (i_branch_met) begin
                    w_state_nxt = c_IDLE;
                end else if (i_mem_data_access != '0) begin
                    w_state_nxt = c_MEM_WAIT;
                    w_cnt_nxt   = i_mem_data_access;
                    w_first_nxt = 1'b1;
                end else if (i_load_use) begin
                    w_state_nxt = c_BUBBLE;
                end
            end
            c_MEM_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1) || w_mem_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_BUBBLE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs for the coming cycle, registered at the same edge as the state
    always_comb begin
        w_stall_nxt = '0;
        w_flush_nxt = '0;
        w_busy_nxt  = 1'b0;
        if (r_state == c_IDLE && i_branch_met) begin
            w_flush_nxt = c_BR_FLUSH;
        end
        case (w_state_nxt)
            c_MEM_WAIT: begin
                w_busy_nxt  = 1'b1;
                // Downstream keeps moving in the first cycle to drain the instruction ahead
                w_stall_nxt = w_first_nxt ? c_UP_MASK : (c_UP_MASK | c_DN_MASK);
            end
            c_BUBBLE: begin
                w_stall_nxt = c_BR_FLUSH;
                w_flush_nxt = c_BR_BIT;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Brief    : Directed scoreboard bench for pipe_stall_ctrl (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

`ifdef PIPE_STALL_MEM_READY_EN
    localparam bit c_RDY_EN = 1'b1;
`else
    localparam bit c_RDY_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] mem_acc;
    logic       branch_met;
    logic       load_use;
    logic       mem_ready;
    logic [4:0] stall;
    logic [4:0] flush;
    logic       busy;

    int checks = 0;
    int passed = 0;
    logic [10:0] sb_q[$];

    pipe_stall_ctrl #(
        .NUM_STAGES(5),
        .CNT_W     (4),
        .MEM_STAGE (3),
        .BR_STAGE  (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_mem_data_access(mem_acc),
        .i_branch_met     (branch_met),
        .i_load_use       (load_use),
        .i_mem_ready      (mem_ready),
        .o_stall_r        (stall),
        .o_flush_r        (flush),
        .o_busy_r         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed stall/flush/busy=%b_%b_%b expected %b_%b_%b",
                    tag, obs[10:6], obs[5:1], obs[0], exp[10:6], exp[5:1], exp[0]);
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge, then compare
    task automatic step(input string tag, input logic [3:0] m, input logic br,
                        input logic lu, input logic rdy,
                        input logic [4:0] es, input logic [4:0] ef, input logic eb);
        logic [10:0] exp;
        mem_acc    = m;
        branch_met = br;
        load_use   = lu;
        mem_ready  = rdy;
        sb_q.push_back({es, ef, eb});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        chk(tag, {stall, flush, busy}, exp);
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_acc    = '0;
        branch_met = 1'b0;
        load_use   = 1'b0;
        mem_ready  = 1'b0;
        #12;
        chk("reset", {stall, flush, busy}, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Request of 3; requests during the wait are ignored
        step("req3_c1", 4'd3, 0, 0, 0, 5'b01111, 5'b00000, 1);
        step("req3_c2", 4'd7, 1, 1, 0, 5'b11111, 5'b00000, 1);
        step("req3_c3", 4'd0, 0, 0, 0, 5'b11111, 5'b00000, 1);
        step("req3_end", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);

        // Request of 1, then back-to-back request of 2 on the first idle cycle
        step("req1_c1", 4'd1, 0, 0, 0, 5'b01111, 5'b00000, 1);
        step("req1_end", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        step("b2b_c1", 4'd2, 0, 0, 0, 5'b01111, 5'b00000, 1);
        step("b2b_c2", 4'd0, 0, 0, 0, 5'b11111, 5'b00000, 1);
        step("b2b_end", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);

        // Branch wins over a simultaneous request; consecutive branches flush twice
        step("br_req", 4'd5, 1, 0, 0, 5'b00000, 5'b00011, 0);
        step("br_drop", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        step("br_a", 4'd0, 1, 0, 0, 5'b00000, 5'b00011, 0);
        step("br_b", 4'd0, 1, 1, 0, 5'b00000, 5'b00011, 0);
        step("br_end", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);

        // Load-use bubble, and load-use absorbed by a memory request
        step("lu", 4'd0, 0, 1, 0, 5'b00011, 5'b00100, 0);
        step("lu_end", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        step("lu_req_c1", 4'd2, 0, 1, 0, 5'b01111, 5'b00000, 1);
        step("lu_req_c2", 4'd0, 0, 0, 0, 5'b11111, 5'b00000, 1);
        step("lu_req_end", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);

        // Maximum count: 15 stall cycles, no wrap
        step("req15_c1", 4'd15, 0, 0, 0, 5'b01111, 5'b00000, 1);
        for (int i = 2; i <= 15; i++)
            step("req15_mid", 4'd0, 0, 0, 0, 5'b11111, 5'b00000, 1);
        step("req15_end", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        step("req15_idle", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);

        // Request of 8 with mem_ready raised in the 3rd stall cycle
        step("rdy_c1", 4'd8, 0, 0, 0, 5'b01111, 5'b00000, 1);
        step("rdy_c2", 4'd0, 0, 0, 0, 5'b11111, 5'b00000, 1);
        step("rdy_c3", 4'd0, 0, 0, 0, 5'b11111, 5'b00000, 1);
        if (c_RDY_EN) begin
            step("rdy_end", 4'd0, 0, 0, 1, 5'b00000, 5'b00000, 0);
        end else begin
            step("rdy_c4", 4'd0, 0, 0, 1, 5'b11111, 5'b00000, 1);
            for (int i = 5; i <= 8; i++)
                step("rdy_full", 4'd0, 0, 0, 0, 5'b11111, 5'b00000, 1);
            step("rdy_full_end", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        end

        // Reset in the 2nd stall cycle of a request of 4
        step("rst_c1", 4'd4, 0, 0, 0, 5'b01111, 5'b00000, 1);
        step("rst_c2", 4'd0, 0, 0, 0, 5'b11111, 5'b00000, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {stall, flush, busy}, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            step("rst_idle", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        step("rst_req1", 4'd1, 0, 0, 0, 5'b01111, 5'b00000, 1);
        step("rst_req1_end", 4'd0, 0, 0, 0, 5'b00000, 5'b00000, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
